// File: rtl/inverse_permute.sv
// Keccak pi-step frame engine: streams 64 slices from a source memory, applies
// inverse pi (mode=0) or forward pi (mode=1), and writes them to a destination memory.

module inverse_permute_ctrl #(
  parameter int LINES  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              finish,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              mode_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINES - 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;      // next read index; MSB set once all LINES reads are issued
  logic              r_busy;
  logic              r_finish;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;    // doubles as the pending-write flag
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_mode;

  // NOTE: every register here updates with <= so all of them see pre-edge values;
  // a blocking assignment would let later statements observe the new value mid-block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_mode    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_finish <= 1'b0;
          if (start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_mode    <= mode;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_cnt     <= (ADDR_W + 1)'(1);
            r_wr_en   <= 1'b0;
          end
        end

        S_RUN: begin
          // The write trails the read by one cycle to match the memory's read latency.
          r_wr_en   <= r_rd_en;
          r_wr_addr <= r_rd_addr;
          if (!r_cnt[ADDR_W]) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_cnt[ADDR_W-1:0];
            r_cnt     <= r_cnt + 1'b1;
          end else begin
            r_rd_en <= 1'b0;
          end
          if (r_wr_en && (r_wr_addr == LAST_ADDR)) begin
            r_state  <= S_DONE;
            r_rd_en  <= 1'b0;
            r_wr_en  <= 1'b0;
            r_finish <= 1'b1;
          end
        end

        S_DONE: begin
          r_finish <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign finish  = r_finish;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign mode_q  = r_mode;

endmodule

// Pure bit routing of one 5x5 slice; bit index is 5*y + x.
module inverse_permute_route (
  input  logic        mode,
  input  logic [24:0] slice_in,
  output logic [24:0] slice_out
);

  logic [24:0] w_inv;
  logic [24:0] w_fwd;

  for (genvar gy = 0; gy < 5; gy++) begin : g_y
    for (genvar gx = 0; gx < 5; gx++) begin : g_x
      // inverse: out[x][y] = in[y][(2x+3y)%5]; forward: out[x][y] = in[(x+3y)%5][x]
      localparam int DST     = 5 * gy + gx;
      localparam int SRC_INV = 5 * ((2 * gx + 3 * gy) % 5) + gy;
      localparam int SRC_FWD = 5 * gx + ((gx + 3 * gy) % 5);
      assign w_inv[DST] = slice_in[SRC_INV];
      assign w_fwd[DST] = slice_in[SRC_FWD];
    end
  end

  assign slice_out = mode ? w_fwd : w_inv;

endmodule

module inverse_permute #(
  parameter int LINES   = 64,
  parameter int ADDR_W  = 6,
  parameter int SLICE_W = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               finish,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SLICE_W-1:0] rd_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SLICE_W-1:0] wr_data
);

  logic         w_mode;
  logic [24:0]  w_perm;

  inverse_permute_ctrl #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .busy    (busy),
    .finish  (finish),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .mode_q  (w_mode)
  );

  inverse_permute_route u_route (
    .mode      (w_mode),
    .slice_in  (rd_data),
    .slice_out (w_perm)
  );

  // Gating keeps wr_data at 0 out of reset and whenever no write is pending.
  assign wr_data = wr_en ? w_perm : '0;

endmodule
